// File: rtl/acc_reg_sat.sv
// Registered accumulator with wrap or saturating addition, a sticky overflow
// flag and a saturating count of overflow events.
module acc_reg_sat #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic             i_valid,
   input  logic             i_sat_mode,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [WIDTH-1:0] o_feedback,
   output logic             o_carry,
   output logic             o_overflow,
   output logic [CNT_W-1:0] o_ovf_count,
   output logic             o_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic             r_ovf;
   logic [CNT_W-1:0] r_ovfCount;
   logic             r_valid;

   logic [WIDTH:0]   w_sum;
   logic             w_carry;

   assign w_sum   = {1'b0, r_acc} + {1'b0, i_data};
   assign w_carry = w_sum[WIDTH];

   // Clear beats load beats accumulate; a coincident addend is simply dropped.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_ovfCount <= '0;
         r_valid    <= 1'b0;
      end else if (i_clr) begin
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_ovfCount <= '0;
         r_valid    <= 1'b0;
      end else if (i_load) begin
         r_acc   <= i_data;
         r_carry <= 1'b0;
         r_valid <= 1'b1;
      end else if (i_valid) begin
         r_valid <= 1'b1;
         r_carry <= w_carry;
         if (w_carry && i_sat_mode) begin
            r_acc <= '1;
         end else begin
            r_acc <= w_sum[WIDTH-1:0];
         end
         if (w_carry) begin
            r_ovf <= 1'b1;
            if (r_ovfCount != CNT_MAX) begin
               r_ovfCount <= r_ovfCount + 1'b1;
            end
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign o_data      = r_acc;
   assign o_feedback  = r_acc;
   assign o_carry     = r_carry;
   assign o_overflow  = r_ovf;
   assign o_ovf_count = r_ovfCount;
   assign o_valid     = r_valid;

endmodule

// File: tb/tb_acc_reg_sat.sv
// Self-checking bench for acc_reg_sat: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_acc_reg_sat;

   localparam int WIDTH = 6;
   localparam int MAXV  = 63;

   logic       clk = 1'b0;
   logic       rstN;
   logic       clr, load, valid, satMode;
   logic [5:0] data;

   logic [5:0] dataA, fbA, dataB, fbB;
   logic       carryA, ovfA, validA, carryB, ovfB, validB;
   logic [3:0] cntA;
   logic [1:0] cntB;

   int nPass  = 0;
   int nTotal = 0;

   int mAcc, mCarry, mOvf, mCnt, mCnt2, mValid;

   acc_reg_sat #(.WIDTH(6), .CNT_W(4)) dutA (
      .clk(clk), .i_rst_n(rstN), .i_clr(clr), .i_load(load), .i_valid(valid),
      .i_sat_mode(satMode), .i_data(data), .o_data(dataA), .o_feedback(fbA),
      .o_carry(carryA), .o_overflow(ovfA), .o_ovf_count(cntA), .o_valid(validA)
   );

   acc_reg_sat #(.WIDTH(6), .CNT_W(2)) dutB (
      .clk(clk), .i_rst_n(rstN), .i_clr(clr), .i_load(load), .i_valid(valid),
      .i_sat_mode(satMode), .i_data(data), .o_data(dataB), .o_feedback(fbB),
      .o_carry(carryB), .o_overflow(ovfB), .o_ovf_count(cntB), .o_valid(validB)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mAcc = 0; mCarry = 0; mOvf = 0; mCnt = 0; mCnt2 = 0; mValid = 0;
   endtask

   task automatic modelStep();
      int sum;
      if (clr) begin
         modelReset();
      end else if (load) begin
         mAcc = int'(data); mCarry = 0; mValid = 1;
      end else if (valid) begin
         sum    = mAcc + int'(data);
         mCarry = (sum > MAXV) ? 1 : 0;
         mValid = 1;
         if (mCarry == 1) begin
            mOvf  = 1;
            mCnt  = (mCnt < 15) ? mCnt + 1 : 15;
            mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
            mAcc  = satMode ? MAXV : sum - (MAXV + 1);
         end else begin
            mAcc = sum;
         end
      end else begin
         mValid = 0;
      end
   endtask

   task automatic doOp(input logic c, input logic l, input logic v, input logic s, input int d);
      clr = c; load = l; valid = v; satMode = s; data = 6'(d);
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0; clr = 0; load = 0; valid = 0; satMode = 0; data = '0;
      #12;
      nTotal++;
      if ({dataA, fbA, carryA, ovfA, cntA, validA} !== '0) $display("[TB] FAIL reset_a: got %h required 0", {dataA, fbA, carryA, ovfA, cntA, validA});
      else nPass++;
      nTotal++;
      if ({dataB, fbB, carryB, ovfB, cntB, validB} !== '0) $display("[TB] FAIL reset_b: got %h required 0", {dataB, fbB, carryB, ovfB, cntB, validB});
      else nPass++;
      @(negedge clk);
      rstN = 1'b1;
      modelReset();
   endtask

   task automatic test_wrap_vector();
      int expD[3] = '{25, 50, 11};
      int expC[3] = '{0, 0, 1};
      for (int i = 0; i < 3; i++) begin
         doOp(0, 0, 1, 0, 25);
         nTotal++;
         if (dataA !== 6'(expD[i]) || fbA !== 6'(expD[i])) $display("[TB] FAIL wrap_data[%0d]: got %0d/%0d required %0d", i, dataA, fbA, expD[i]);
         else nPass++;
         nTotal++;
         if (carryA !== 1'(expC[i]) || validA !== 1'b1) $display("[TB] FAIL wrap_carry_valid[%0d]: got %b/%b required %0d/1", i, carryA, validA, expC[i]);
         else nPass++;
      end
      nTotal++;
      if (ovfA !== 1'b1 || cntA !== 4'd1) $display("[TB] FAIL wrap_ovf: got %b/%0d required 1/1", ovfA, cntA);
      else nPass++;
   endtask

   task automatic test_sat_vector();
      doOp(1, 0, 0, 0, 0);
      doOp(0, 1, 0, 1, 50);
      doOp(0, 0, 1, 1, 25);
      nTotal++;
      if (dataA !== 6'd63 || carryA !== 1'b1 || ovfA !== 1'b1) $display("[TB] FAIL sat_first: got %0d/%b/%b required 63/1/1", dataA, carryA, ovfA);
      else nPass++;
      doOp(0, 0, 1, 1, 1);
      nTotal++;
      if (dataA !== 6'd63 || cntA !== 4'd2) $display("[TB] FAIL sat_second: got %0d/%0d required 63/2", dataA, cntA);
      else nPass++;
   endtask

   task automatic test_load_sticky();
      doOp(0, 1, 0, 0, 10);
      nTotal++;
      if (dataA !== 6'd10 || carryA !== 1'b0 || ovfA !== 1'b1 || validA !== 1'b1) $display("[TB] FAIL load_sticky: got %0d/%b/%b/%b required 10/0/1/1", dataA, carryA, ovfA, validA);
      else nPass++;
      doOp(0, 0, 0, 0, 0);
      nTotal++;
      if (validA !== 1'b0 || dataA !== 6'd10) $display("[TB] FAIL load_pulse_once: got valid %b data %0d required 0/10", validA, dataA);
      else nPass++;
   endtask

   task automatic test_clear_priority();
      doOp(0, 1, 0, 0, 40);
      nTotal++;
      if (dataA !== 6'd40 || ovfA !== 1'b1) $display("[TB] FAIL clr_setup: got %0d/%b required 40/1", dataA, ovfA);
      else nPass++;
      doOp(1, 1, 1, 1, 63);
      nTotal++;
      if (dataA !== 6'd0 || ovfA !== 1'b0 || cntA !== 4'd0 || validA !== 1'b0 || carryA !== 1'b0) $display("[TB] FAIL clr_priority: got %0d/%b/%0d/%b/%b required 0/0/0/0/0", dataA, ovfA, cntA, validA, carryA);
      else nPass++;
   endtask

   task automatic test_cnt_saturate();
      doOp(0, 1, 0, 0, 63);
      for (int i = 0; i < 5; i++) begin
         doOp(0, 0, 1, 0, 63);
         nTotal++;
         if (carryA !== 1'b1 || dataA !== 6'(62 - i)) $display("[TB] FAIL cnt_event[%0d]: got carry %b data %0d required 1/%0d", i, carryA, dataA, 62 - i);
         else nPass++;
      end
      nTotal++;
      if (cntB !== 2'd3 || ovfB !== 1'b1) $display("[TB] FAIL cnt_sat_narrow: got %0d/%b required 3/1", cntB, ovfB);
      else nPass++;
      nTotal++;
      if (cntA !== 4'd5) $display("[TB] FAIL cnt_wide: got %0d required 5", cntA);
      else nPass++;
   endtask

   task automatic test_zero_addend();
      doOp(0, 0, 1, 0, 0);
      nTotal++;
      if (dataA !== 6'd58 || carryA !== 1'b0 || validA !== 1'b1 || cntA !== 4'd5) $display("[TB] FAIL zero_addend: got %0d/%b/%b/%0d required 58/0/1/5", dataA, carryA, validA, cntA);
      else nPass++;
      doOp(0, 1, 1, 0, 63);
      nTotal++;
      if (dataA !== 6'd63 || cntA !== 4'd5 || carryA !== 1'b0) $display("[TB] FAIL load_drops_addend: got %0d/%0d/%b required 63/5/0", dataA, cntA, carryA);
      else nPass++;
   endtask

   task automatic test_hold();
      doOp(0, 0, 0, 1, 5);
      nTotal++;
      if (validA !== 1'b0 || dataA !== 6'd63 || carryA !== 1'b0 || cntA !== 4'd5 || ovfA !== 1'b1) $display("[TB] FAIL hold: got %b/%0d/%b/%0d/%b required 0/63/0/5/1", validA, dataA, carryA, cntA, ovfA);
      else nPass++;
   endtask

   task automatic test_async_reset();
      doOp(1, 0, 0, 0, 0);
      doOp(0, 0, 1, 0, 20);
      doOp(0, 0, 1, 0, 20);
      #2 rstN = 1'b0;
      #1;
      nTotal++;
      if ({dataA, fbA, carryA, ovfA, cntA, validA, dataB, cntB, validB} !== '0) $display("[TB] FAIL async_reset: got %h required 0", {dataA, fbA, carryA, ovfA, cntA, validA, dataB, cntB, validB});
      else nPass++;
      #2 rstN = 1'b1;
      modelReset();
      doOp(0, 0, 1, 0, 7);
      nTotal++;
      if (dataA !== 6'd7 || validA !== 1'b1 || carryA !== 1'b0) $display("[TB] FAIL after_reset: got %0d/%b/%b required 7/1/0", dataA, validA, carryA);
      else nPass++;
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         doOp(r < 3, (r >= 3 && r < 13), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
         nTotal++;
         if (dataA !== 6'(mAcc) || fbA !== 6'(mAcc) || carryA !== 1'(mCarry) || validA !== 1'(mValid)) $display("[TB] FAIL rand_a_data[%0d]: got %0d/%0d/%b/%b required %0d/%0d/%0d/%0d", i, dataA, fbA, carryA, validA, mAcc, mAcc, mCarry, mValid);
         else nPass++;
         nTotal++;
         if (ovfA !== 1'(mOvf) || cntA !== 4'(mCnt)) $display("[TB] FAIL rand_a_ovf[%0d]: got %b/%0d required %0d/%0d", i, ovfA, cntA, mOvf, mCnt);
         else nPass++;
         nTotal++;
         if (dataB !== 6'(mAcc) || ovfB !== 1'(mOvf) || cntB !== 2'(mCnt2) || validB !== 1'(mValid)) $display("[TB] FAIL rand_b[%0d]: got %0d/%b/%0d/%b required %0d/%0d/%0d/%0d", i, dataB, ovfB, cntB, validB, mAcc, mOvf, mCnt2, mValid);
         else nPass++;
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_wrap_vector();
      test_sat_vector();
      test_load_sticky();
      test_clear_priority();
      test_cnt_saturate();
      test_zero_addend();
      test_hold();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
